// File: rtl/pu_load_sched.sv
// Window-load sequencer for one img2col PU: turns 2-pixel beats into register-file writes, fires the PU per window.
// First write 2 cycles after cfg_go; in_ready only in LOAD; PU_SCHED_PERF_EN adds the LOAD starvation counter stall_cnt.
module pu_load_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int KSIZE      = 5,
  parameter int ADDR_W     = 5,
  parameter int ROUND_W    = 6,
  parameter int NUM_ROUNDS = 28
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cfg_go,
  input  logic                  cfg_abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  output logic [DATA_WIDTH-1:0] new1,
  output logic [DATA_WIDTH-1:0] new2,
  output logic [ADDR_W-1:0]     adrs_in1,
  output logic [ADDR_W-1:0]     adrs_in2,
  output logic                  wr_en1,
  output logic                  wr_en2,
  output logic                  pu_start,
  output logic [ROUND_W-1:0]    round,
  input  logic                  pu_done,
  output logic                  busy,
  output logic                  row_done,
  output logic [15:0]           stall_cnt
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]   WIN_C      = CNT_W'(KSIZE * KSIZE);
  localparam logic [CNT_W-1:0]   KSIZE_C    = CNT_W'(KSIZE);
  localparam logic [ADDR_W-1:0]  BASE_C     = ADDR_W'(KSIZE * (KSIZE - 1));
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      target_q, target_d;
  logic [ROUND_W-1:0]    round_q, round_d;
  logic                  wr_en1_q, wr_en1_d;
  logic                  wr_en2_q, wr_en2_d;
  logic [ADDR_W-1:0]     adrs1_q, adrs1_d;
  logic [ADDR_W-1:0]     adrs2_q, adrs2_d;
  logic [DATA_WIDTH-1:0] new1_q, new1_d;
  logic [DATA_WIDTH-1:0] new2_q, new2_d;
  logic                  pu_start_q, pu_start_d;
  logic                  row_done_q, row_done_d;

  logic [ADDR_W-1:0]     base;
  logic [CNT_W-1:0]      cnt_p1;

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign round    = round_q;
  assign wr_en1   = wr_en1_q;
  assign wr_en2   = wr_en2_q;
  assign adrs_in1 = adrs1_q;
  assign adrs_in2 = adrs2_q;
  assign new1     = new1_q;
  assign new2     = new2_q;
  assign pu_start = pu_start_q;
  assign row_done = row_done_q;

  // Later rounds only refresh the newest column, which lives in the top KSIZE entries.
  assign base   = (round_q == '0) ? '0 : BASE_C;
  assign cnt_p1 = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    round_d    = round_q;
    wr_en1_d   = 1'b0;
    wr_en2_d   = 1'b0;
    adrs1_d    = adrs1_q;
    adrs2_d    = adrs2_q;
    new1_d     = new1_q;
    new2_d     = new2_q;
    pu_start_d = 1'b0;
    row_done_d = 1'b0;

    if (cfg_abort) begin
      state_d = S_IDLE;
      round_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_go) begin
            state_d  = S_LOAD;
            round_d  = '0;
            cnt_d    = '0;
            target_d = WIN_C;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            wr_en1_d = 1'b1;
            adrs1_d  = base + cnt_q[ADDR_W-1:0];
            new1_d   = in_data1;
            // Odd window tail: second pixel of the final beat has no slot.
            if (cnt_p1 < target_q) begin
              wr_en2_d = 1'b1;
              adrs2_d  = base + cnt_p1[ADDR_W-1:0];
              new2_d   = in_data2;
            end
            cnt_d = cnt_q + CNT_W'(2);
            if (cnt_q + CNT_W'(2) >= target_q) state_d = S_FIRE;
          end
        end
        S_FIRE: begin
          pu_start_d = 1'b1;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          // A done flag coincident with the start pulse belongs to the previous window.
          if (pu_done && !pu_start_q) begin
            if (round_q == LAST_ROUND) begin
              state_d    = S_IDLE;
              row_done_d = 1'b1;
              round_d    = '0;
            end else begin
              state_d  = S_LOAD;
              round_d  = round_q + ROUND_W'(1);
              cnt_d    = '0;
              target_d = KSIZE_C;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      round_q    <= '0;
      wr_en1_q   <= 1'b0;
      wr_en2_q   <= 1'b0;
      adrs1_q    <= '0;
      adrs2_q    <= '0;
      new1_q     <= '0;
      new2_q     <= '0;
      pu_start_q <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      round_q    <= round_d;
      wr_en1_q   <= wr_en1_d;
      wr_en2_q   <= wr_en2_d;
      adrs1_q    <= adrs1_d;
      adrs2_q    <= adrs2_d;
      new1_q     <= new1_d;
      new2_q     <= new2_d;
      pu_start_q <= pu_start_d;
      row_done_q <= row_done_d;
    end
  end

`ifdef PU_SCHED_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && cfg_go && !cfg_abort) begin
      stall_d = '0;
    end else if (state_q == S_LOAD && !in_valid && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pu_load_sched.sv
// Self-checking bench for pu_load_sched (KSIZE=5, NUM_ROUNDS=2): directed table plus randomized rows.
module tb_pu_load_sched;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int RW = 6;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          nrst;
  logic          cfg_go, cfg_abort, in_valid, in_ready, pu_done;
  logic [DW-1:0] in_data1, in_data2, new1, new2;
  logic [AW-1:0] adrs_in1, adrs_in2;
  logic          wr_en1, wr_en2, pu_start, busy, row_done;
  logic [RW-1:0] round;
  logic [15:0]   stall_cnt;

  pu_load_sched #(.DATA_WIDTH(DW), .KSIZE(5), .ADDR_W(AW), .ROUND_W(RW), .NUM_ROUNDS(NR)) dut (
    .clk(clk), .nrst(nrst), .cfg_go(cfg_go), .cfg_abort(cfg_abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data1(in_data1), .in_data2(in_data2),
    .new1(new1), .new2(new2), .adrs_in1(adrs_in1), .adrs_in2(adrs_in2),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .pu_start(pu_start), .round(round),
    .pu_done(pu_done), .busy(busy), .row_done(row_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stall_exp = 0;

  typedef struct {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [4:0]  a1;
    logic        w2;
    logic [4:0]  a2;
  } vec_t;
  vec_t vec[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_stall();
`ifdef PU_SCHED_PERF_EN
    return stall_exp;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row();
    chk("idle_busy", busy, 0);
    cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    stall_exp = 0;
    chk("go_busy", busy, 1);
    chk("go_in_ready", in_ready, 1);
    chk("go_round", round, 0);
  endtask

  task automatic apply_vec(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      chk("dir_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data1 = vec[i].d1;
      in_data2 = vec[i].d2;
      tick();
      chk("dir_wr_en1", wr_en1, 1);
      chk("dir_adrs1", adrs_in1, vec[i].a1);
      chk("dir_new1", new1, vec[i].d1);
      chk("dir_wr_en2", wr_en2, vec[i].w2);
      if (vec[i].w2) begin
        chk("dir_adrs2", adrs_in2, vec[i].a2);
        chk("dir_new2", new2, vec[i].d2);
      end
    end
    in_valid = 1'b0;
  endtask

  // Model: beat k of a round fills entries 2k and 2k+1 of the round's target set.
  task automatic load_round(input int r, input int pct);
    int target, base, nb, k, cyc;
    logic v;
    logic [15:0] d1, d2;
    target = (r == 0) ? 25 : 5;
    base   = (r == 0) ? 0 : 20;
    nb     = (target + 1) / 2;
    k      = 0;
    cyc    = 0;
    while (k < nb && cyc < 1000) begin
      chk("rnd_in_ready", in_ready, 1);
      v  = ($urandom_range(99) < pct);
      d1 = 16'($urandom);
      d2 = 16'($urandom);
      in_valid = v;
      in_data1 = d1;
      in_data2 = d2;
      if (!v) stall_exp++;
      tick();
      cyc++;
      chk("rnd_wr_en1", wr_en1, v);
      if (v) begin
        chk("rnd_adrs1", adrs_in1, base + 2 * k);
        chk("rnd_new1", new1, d1);
        chk("rnd_wr_en2", wr_en2, (2 * k + 1 < target));
        if (2 * k + 1 < target) begin
          chk("rnd_adrs2", adrs_in2, base + 2 * k + 1);
          chk("rnd_new2", new2, d2);
        end
        k++;
      end else begin
        chk("rnd_idle_wr_en2", wr_en2, 0);
      end
    end
    in_valid = 1'b0;
    chk("rnd_beats_done", k, nb);
    chk("rnd_stall_cnt", stall_cnt, exp_stall());
  endtask

  task automatic check_fire(input int r);
    chk("fire_in_ready", in_ready, 0);
    chk("fire_start_not_early", pu_start, 0);
    tick();
    chk("pu_start", pu_start, 1);
    chk("start_round", round, r);
    chk("start_wr_en1", wr_en1, 0);
    pu_done = 1'b1;
    tick();
    pu_done = 1'b0;
    chk("start_one_cycle", pu_start, 0);
    chk("early_done_ignored", in_ready, 0);
    chk("wait_busy", busy, 1);
    chk("wait_round", round, r);
  endtask

  task automatic finish_round(input int r, input int delay);
    repeat (delay) tick();
    chk("wait_hold_ready", in_ready, 0);
    pu_done = 1'b1;
    tick();
    pu_done = 1'b0;
    if (r == NR - 1) begin
      chk("row_done", row_done, 1);
      chk("row_busy", busy, 0);
      chk("row_round", round, 0);
      tick();
      chk("row_done_pulse", row_done, 0);
    end else begin
      chk("next_in_ready", in_ready, 1);
      chk("next_round", round, r + 1);
      chk("next_row_done", row_done, 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 13; k++) begin
      vec[k].d1 = 16'(2 * k + 1);
      vec[k].d2 = 16'(2 * k + 2);
      vec[k].a1 = 5'(2 * k);
      vec[k].w2 = (k < 12);
      vec[k].a2 = 5'(2 * k + 1);
    end
    vec[13] = '{16'd101, 16'd102, 5'd20, 1'b1, 5'd21};
    vec[14] = '{16'd103, 16'd104, 5'd22, 1'b1, 5'd23};
    vec[15] = '{16'd105, 16'd106, 5'd24, 1'b0, 5'd0};

    nrst = 1'b0; cfg_go = 1'b0; cfg_abort = 1'b0; in_valid = 1'b0;
    pu_done = 1'b0; in_data1 = '0; in_data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en1", wr_en1, 0);
    chk("rst_wr_en2", wr_en2, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pu_start", pu_start, 0);
    chk("rst_row_done", row_done, 0);
    chk("rst_round", round, 0);
    chk("rst_adrs1", adrs_in1, 0);
    chk("rst_stall", stall_cnt, 0);
    nrst = 1'b1;
    tick();

    // Directed row, pixels 1..26 then round 1
    start_row();
    apply_vec(0, 13);
    check_fire(0);
    finish_round(0, 2);
    apply_vec(13, 3);
    check_fire(1);
    finish_round(1, 0);

    // Randomized rows with bursty in_valid
    for (int row = 0; row < 6; row++) begin
      start_row();
      load_round(0, $urandom_range(100, 30));
      check_fire(0);
      finish_round(0, $urandom_range(3));
      load_round(1, $urandom_range(100, 30));
      check_fire(1);
      finish_round(1, $urandom_range(3));
    end

    // Abort in WAIT; later pu_done must be ignored
    start_row();
    load_round(0, 60);
    check_fire(0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_round", round, 0);
    pu_done = 1'b1;
    tick();
    pu_done = 1'b0;
    chk("abort_no_row_done", row_done, 0);
    chk("abort_done_ignored", busy, 0);
    chk("abort_no_start", pu_start, 0);
    chk("abort_keeps_stall", stall_cnt, exp_stall());

    // Abort beats go in IDLE
    cfg_go = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_go = 1'b0;
    cfg_abort = 1'b0;
    chk("abort_go_busy", busy, 0);
    chk("abort_go_stall", stall_cnt, exp_stall());

    // Abort mid-LOAD suppresses the in-flight write
    start_row();
    in_valid = 1'b1;
    tick();
    chk("pre_abort_wr", wr_en1, 1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_load_wr1", wr_en1, 0);
    chk("abort_load_wr2", wr_en2, 0);
    chk("abort_load_busy", busy, 0);

    // Reset mid-LOAD after 4 beats
    start_row();
    in_valid = 1'b1;
    in_data1 = 16'h1234;
    repeat (4) tick();
    #2;
    nrst = 1'b0;
    #1;
    stall_exp = 0;
    chk("mid_rst_wr_en1", wr_en1, 0);
    chk("mid_rst_adrs1", adrs_in1, 0);
    chk("mid_rst_new1", new1, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    in_valid = 1'b0;
    nrst = 1'b1;
    tick();
    start_row();
    load_round(0, 100);
    check_fire(0);
    finish_round(0, 0);
    load_round(1, 70);
    check_fire(1);
    finish_round(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
